adjust_digit_ctrl: RTL and testbench

//  Button-side controller for time adjustment on the stopwatch/watch board. Synchronises and

---
 rtl/adjust_digit_if.sv | 14 +
 rtl/adjust_digit_ctrl.sv | 97 +++++++++
 tb/tb_adjust_digit_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/adjust_digit_if.sv
// adjust_digit_if: button inputs and adjust outputs between the board side and the adjust controller
interface adjust_digit_if;
  logic       btn_c, btn_r, btn_l, btn_u, btn_d, run_lock;
  logic [3:0] adjust_digit_sel;
  logic       adjust_active, inc_pulse, dec_pulse;
  modport master (
    output btn_c, btn_r, btn_l, btn_u, btn_d, run_lock,
    input  adjust_digit_sel, adjust_active, inc_pulse, dec_pulse
  );
  modport slave (
    input  btn_c, btn_r, btn_l, btn_u, btn_d, run_lock,
    output adjust_digit_sel, adjust_active, inc_pulse, dec_pulse
  );
endinterface

// File: rtl/adjust_digit_ctrl.sv
// adjust_digit_ctrl: sync/debounce five buttons and run the IDLE/ADJUST digit-adjust FSM
// Optional auto-exit after TIMEOUT_CYCLES idle cycles when ADJUST_TIMEOUT_EN is defined.
module adjust_digit_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 500_000_000
) (
  input logic          clk,
  input logic          rst,
  adjust_digit_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic {IDLE, ADJUST} state_t;
  // Bit order throughout: {c, r, l, u, d}
  logic [4:0]    raw, s1_q, s2_q, db_q, press_q, flip;
  logic [DW-1:0] cnt_q [5];
  state_t        state_q, state_d;
  logic [3:0]    sel_q, sel_d;
  logic          inc_q, inc_d, dec_q, dec_d;
  assign raw = {bus.btn_c, bus.btn_r, bus.btn_l, bus.btn_u, bus.btn_d};
  always_comb begin
    flip = '0;
    for (int k = 0; k < 5; k++)
      flip[k] = (s2_q[k] != db_q[k]) && (cnt_q[k] == DW'(DEBOUNCE_CYCLES - 1));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      db_q    <= '0;
      press_q <= '0;
      for (int k = 0; k < 5; k++) cnt_q[k] <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      db_q    <= db_q ^ flip;
      press_q <= flip & ~db_q;
      for (int k = 0; k < 5; k++)
        cnt_q[k] <= (s2_q[k] == db_q[k] || flip[k]) ? '0 : cnt_q[k] + DW'(1);
    end
`ifdef ADJUST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) to_q <= '0;
    else     to_q <= to_d;
`endif
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
`ifdef ADJUST_TIMEOUT_EN
    to_d    = '0;
`endif
    if (bus.run_lock) begin
      state_d = IDLE;
      sel_d   = 4'b0000;
    end else if (state_q == IDLE) begin
      if (press_q[4]) begin
        state_d = ADJUST;
        sel_d   = 4'b0001;
      end
`ifdef ADJUST_TIMEOUT_EN
    end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      sel_d   = 4'b0000;
`endif
    end else begin
`ifdef ADJUST_TIMEOUT_EN
      to_d = |press_q ? '0 : to_q + TW'(1);
`endif
      if (press_q[4]) begin
        state_d = IDLE;
        sel_d   = 4'b0000;
      end else if (press_q[3]) sel_d = {sel_q[2:0], sel_q[3]};
      else if (press_q[2])     sel_d = {sel_q[0], sel_q[3:1]};
      else if (press_q[1])     inc_d = 1'b1;
      else if (press_q[0])     dec_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 4'b0000;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  assign bus.adjust_digit_sel = sel_q;
  assign bus.adjust_active    = (state_q == ADJUST);
  assign bus.inc_pulse        = inc_q;
  assign bus.dec_pulse        = dec_q;
endmodule

// File: tb/tb_adjust_digit_ctrl.sv
// tb_adjust_digit_ctrl: table-driven and directed checks of the adjust controller
module tb_adjust_digit_ctrl;
  localparam logic [4:0] N = 5'b00000, C = 5'b10000, R = 5'b01000, L = 5'b00100, U = 5'b00010, D = 5'b00001;
  typedef struct {
    logic [4:0] btn;
    logic       lock;
    int         hold;
    logic [3:0] sel;
    logic       act;
    int         inc;
    int         dec;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0, errors = 0, n_inc = 0, n_dec = 0, i0, d0;
  vec_t v [25];
  adjust_digit_if bus ();
  adjust_digit_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    n_inc += int'(bus.inc_pulse);
    n_dec += int'(bus.dec_pulse);
    checks++;
    if (!$onehot0(bus.adjust_digit_sel) || (bus.inc_pulse && bus.dec_pulse)) begin
      errors++;
      $display("FAIL invariant: sel=%b inc=%b dec=%b, required one-hot0 sel and not both pulses",
               bus.adjust_digit_sel, bus.inc_pulse, bus.dec_pulse);
    end
  endtask
  task automatic drive(input logic [4:0] b);
    {bus.btn_c, bus.btn_r, bus.btn_l, bus.btn_u, bus.btn_d} = b;
  endtask
  task automatic press(input logic [4:0] b, input int hold);
    drive(b);
    repeat (hold) step();
    drive(N);
    repeat (10) step();
  endtask
  initial begin
    v[0]  = '{U,     1'b0, 8, 4'b0000, 1'b0, 0, 0};
    v[1]  = '{R,     1'b0, 8, 4'b0000, 1'b0, 0, 0};
    v[2]  = '{C,     1'b0, 8, 4'b0001, 1'b1, 0, 0};
    v[3]  = '{R,     1'b0, 8, 4'b0010, 1'b1, 0, 0};
    v[4]  = '{R,     1'b0, 8, 4'b0100, 1'b1, 0, 0};
    v[5]  = '{R,     1'b0, 8, 4'b1000, 1'b1, 0, 0};
    v[6]  = '{R,     1'b0, 8, 4'b0001, 1'b1, 0, 0};
    v[7]  = '{R,     1'b0, 8, 4'b0010, 1'b1, 0, 0};
    v[8]  = '{L,     1'b0, 8, 4'b0001, 1'b1, 0, 0};
    v[9]  = '{L,     1'b0, 8, 4'b1000, 1'b1, 0, 0};
    v[10] = '{U,     1'b0, 8, 4'b1000, 1'b1, 1, 0};
    v[11] = '{D,     1'b0, 8, 4'b1000, 1'b1, 0, 1};
    v[12] = '{U,     1'b0, 2, 4'b1000, 1'b1, 0, 0};
    v[13] = '{U,     1'b0, 6, 4'b1000, 1'b1, 1, 0};
    v[14] = '{C | U, 1'b0, 8, 4'b0000, 1'b0, 0, 0};
    v[15] = '{C,     1'b0, 8, 4'b0001, 1'b1, 0, 0};
    v[16] = '{R | L, 1'b0, 8, 4'b0010, 1'b1, 0, 0};
    v[17] = '{L | U, 1'b0, 8, 4'b0001, 1'b1, 0, 0};
    v[18] = '{U | D, 1'b0, 8, 4'b0001, 1'b1, 1, 0};
    v[19] = '{R,     1'b0, 8, 4'b0010, 1'b1, 0, 0};
    v[20] = '{R,     1'b0, 8, 4'b0100, 1'b1, 0, 0};
    v[21] = '{C,     1'b1, 8, 4'b0000, 1'b0, 0, 0};
    v[22] = '{C,     1'b0, 8, 4'b0001, 1'b1, 0, 0};
    v[23] = '{C,     1'b0, 8, 4'b0000, 1'b0, 0, 0};
    v[24] = '{D,     1'b0, 8, 4'b0000, 1'b0, 0, 0};
    rst = 1'b1;
    bus.run_lock = 1'b0;
    drive(N);
    #12;
    chk("reset sel", int'(bus.adjust_digit_sel), 0);
    chk("reset active", int'(bus.adjust_active), 0);
    chk("reset inc", int'(bus.inc_pulse), 0);
    chk("reset dec", int'(bus.dec_pulse), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step();
    // Entry latency: 2 sync + 4 debounce + 1 FSM cycles
    i0 = n_inc;
    d0 = n_dec;
    drive(C);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 6) chk("latency active@6", int'(bus.adjust_active), 0);
      if (k == 7) chk("latency active@7", int'(bus.adjust_active), 1);
      if (k == 7) chk("latency sel@7", int'(bus.adjust_digit_sel), 1);
    end
    drive(N);
    repeat (10) step();
    chk("latency no inc", n_inc - i0, 0);
    chk("latency no dec", n_dec - d0, 0);
    press(C, 8);
    chk("latency exit", int'(bus.adjust_active), 0);
    for (int n = 0; n < 25; n++) begin
      i0 = n_inc;
      d0 = n_dec;
      bus.run_lock = v[n].lock;
      press(v[n].btn, v[n].hold);
      chk($sformatf("v%0d sel", n), int'(bus.adjust_digit_sel), int'(v[n].sel));
      chk($sformatf("v%0d active", n), int'(bus.adjust_active), int'(v[n].act));
      chk($sformatf("v%0d inc", n), n_inc - i0, v[n].inc);
      chk($sformatf("v%0d dec", n), n_dec - d0, v[n].dec);
      bus.run_lock = 1'b0;
    end
    press(C, 8);
    press(R, 8);
    press(R, 8);
    chk("lock pre sel", int'(bus.adjust_digit_sel), 4);
    bus.run_lock = 1'b1;
    step();
    chk("lock next sel", int'(bus.adjust_digit_sel), 0);
    chk("lock next active", int'(bus.adjust_active), 0);
    press(C, 8);
    bus.run_lock = 1'b0;
    repeat (3) step();
    chk("lock press discarded", int'(bus.adjust_active), 0);
`ifdef ADJUST_TIMEOUT_EN
    drive(C);
    repeat (7) step();
    chk("to entry", int'(bus.adjust_active), 1);
    drive(N);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 19) chk("to active@19", int'(bus.adjust_active), 1);
      if (k == 20) chk("to sel@20", int'(bus.adjust_digit_sel), 0);
      if (k == 20) chk("to active@20", int'(bus.adjust_active), 0);
    end
    repeat (5) step();
    i0 = n_inc;
    drive(C);
    repeat (7) step();
    drive(N);
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 8) drive(U);
      if (k == 14) drive(N);
      if (k == 34) chk("to restart active@34", int'(bus.adjust_active), 1);
      if (k == 35) chk("to restart active@35", int'(bus.adjust_active), 0);
    end
    chk("to restart inc", n_inc - i0, 1);
`else
    press(C, 8);
    repeat (1000) step();
    chk("no timeout active", int'(bus.adjust_active), 1);
    chk("no timeout sel", int'(bus.adjust_digit_sel), 1);
    press(C, 8);
`endif
    press(C, 8);
    chk("pre reset active", int'(bus.adjust_active), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset sel", int'(bus.adjust_digit_sel), 0);
    chk("async reset active", int'(bus.adjust_active), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    i0 = n_inc;
    d0 = n_dec;
    repeat (10) step();
    chk("post reset active", int'(bus.adjust_active), 0);
    drive(C);
    repeat (4) step();
    rst = 1'b1;
    drive(N);
    step();
    rst = 1'b0;
    repeat (12) step();
    chk("mid debounce reset active", int'(bus.adjust_active), 0);
    chk("reset no inc", n_inc - i0, 0);
    chk("reset no dec", n_dec - d0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
